image_read_stream: RTL and testbench

//  Source end of the pixel-pair stream consumed by the BMP writer. Reads a frame

---
 rtl/image_read_stream_pkg.sv | 43 ++++
 rtl/image_read_stream_if.sv | 25 ++
 rtl/image_read_stream_addr_gen.sv | 47 ++++
 rtl/image_read_stream.sv | 143 ++++++++++++++
 tb/tb_image_read_stream.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/image_read_stream_pkg.sv
// Shared definitions for the frame reader and the BMP writer chain:
// FSM encoding, byte lanes of the 48-bit pixel-pair word, frame defaults.
package img_pkg;

    localparam int IMG_WIDTH  = 512;
    localparam int IMG_HEIGHT = 512;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_HBLANK = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Byte-lane LSB positions inside {R1,G1,B1,R0,G0,B0}
    localparam int B0_LSB = 0;
    localparam int G0_LSB = 8;
    localparam int R0_LSB = 16;
    localparam int B1_LSB = 24;
    localparam int G1_LSB = 32;
    localparam int R1_LSB = 40;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Extract the left (odd=0) or right (odd=1) pixel of a pair word
    function automatic rgb_t get_pix(input logic [47:0] w, input logic odd);
        rgb_t p;
        if (odd) begin
            p.r = w[R1_LSB +: 8];
            p.g = w[G1_LSB +: 8];
            p.b = w[B1_LSB +: 8];
        end else begin
            p.r = w[R0_LSB +: 8];
            p.g = w[G0_LSB +: 8];
            p.b = w[B0_LSB +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/image_read_stream_if.sv
// Frame-buffer read port plus the outgoing pixel-pair stream.
// master = the reader, slave = RAM + downstream consumer.
interface image_read_stream_if #(
    parameter int ADDR_W = 17
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [47:0]       mem_rdata;
    logic              VSYNC;
    logic              HSYNC;
    logic [7:0]        DATA_R0, DATA_G0, DATA_B0;
    logic [7:0]        DATA_R1, DATA_G1, DATA_B1;

    modport master (
        output mem_rd, mem_addr, VSYNC, HSYNC,
               DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr, VSYNC, HSYNC,
               DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
        output mem_rdata
    );
endinterface

// File: rtl/image_read_stream_addr_gen.sv
// Row/column counters and bottom-up BMP word address.
// Counters advance once per read; held at zero while the reader is idle.
module img_addr_gen #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int ADDR_W = 17
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              clr,
    input  logic              adv,
    output logic              col_last,
    output logic              row_last,
    output logic [ADDR_W-1:0] addr
);
    localparam int COLS  = WIDTH / 2;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    assign col_last = (col_q == COL_W'(COLS - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));

    // Rows are stored bottom-up, so the first emitted row is the last stored one
    assign addr = (ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q)) * ADDR_W'(COLS) + ADDR_W'(col_q);

    // Column steps each read; wraps and bumps the row on the last pair of a row
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_read_stream.sv
// Frame reader: pulls a bottom-up BGR frame from a synchronous RAM and
// emits it top-row-first as RGB888 pixel pairs framed by VSYNC/HSYNC.
module image_read_stream
    import img_pkg::*;
#(
    parameter int WIDTH          = IMG_WIDTH,
    parameter int HEIGHT         = IMG_HEIGHT,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter int ADDR_W         = 17
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    output logic                busy,
    output logic                ctrl_done,
    image_read_stream_if.master bus
);
    localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] SUD_LOAD = DLY_W'(START_UP_DELAY - 1);
    localparam logic [DLY_W-1:0] HSD_LOAD = DLY_W'(HSYNC_DELAY - 1);

    logic [2:0]        state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              rd;
    logic              col_last, row_last;
    logic [ADDR_W-1:0] addr;
    logic              hsync_q;
    logic              done_q;
    logic [47:0]       pair_q, pair_out;
    rgb_t              px0, px1;

    assign rd        = (state_q == ST_DATA);
    assign busy      = (state_q != ST_IDLE);
    assign ctrl_done = done_q;

    img_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .clr      (state_q == ST_IDLE),
        .adv      (rd),
        .col_last (col_last),
        .row_last (row_last),
        .addr     (addr)
    );

    // Next-state and delay reload; start in the ctrl_done cycle is dropped
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d = ST_VSYNC;
                    dly_d   = SUD_LOAD;
                end
            end
            ST_VSYNC: begin
                if (dly_q == '0) begin
                    state_d = ST_HBLANK;
                    dly_d   = HSD_LOAD;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_HBLANK: begin
                if (dly_q == '0) begin
                    state_d = ST_DATA;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_DATA: begin
                if (col_last) begin
                    if (row_last) begin
                        state_d = ST_DONE;
                        dly_d   = '0;
                    end else begin
                        state_d = ST_HBLANK;
                        dly_d   = HSD_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                dly_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                dly_d   = '0;
            end
        endcase
    end

    // FSM state and delay counter registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    // HSYNC trails the read strobe by the RAM latency; done pulses after DONE.
    // pair_q keeps the last valid pair so DATA_* hold while HSYNC is low.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
            pair_q  <= '0;
        end else begin
            hsync_q <= rd;
            done_q  <= (state_q == ST_DONE);
            if (hsync_q)
                pair_q <= bus.mem_rdata;
        end
    end

    // While HSYNC is high the returning RAM word is the pair; else replay the held one
    assign pair_out = hsync_q ? bus.mem_rdata : pair_q;
    assign px0      = get_pix(pair_out, 1'b0);
    assign px1      = get_pix(pair_out, 1'b1);

    assign bus.mem_rd   = rd;
    assign bus.mem_addr = rd ? addr : '0;
    assign bus.VSYNC    = (state_q == ST_VSYNC);
    assign bus.HSYNC    = hsync_q;
    assign bus.DATA_R0  = px0.r;
    assign bus.DATA_G0  = px0.g;
    assign bus.DATA_B0  = px0.b;
    assign bus.DATA_R1  = px1.r;
    assign bus.DATA_G1  = px1.g;
    assign bus.DATA_B1  = px1.b;

endmodule

// File: tb/tb_image_read_stream.sv
// Directed bench for image_read_stream: 8x4 frame, 3 VSYNC, 2 blanking cycles.
// RAM model returns a per-byte pattern derived from the word address.
module tb_image_read_stream;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int SUD  = 3;
    localparam int HSD  = 2;
    localparam int AW   = 4;
    localparam int LAST = 29;   // ctrl_done cycle relative to start cycle 0

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    logic start   = 1'b0;
    logic busy;
    logic ctrl_done;

    image_read_stream_if #(.ADDR_W(AW)) bus();

    image_read_stream #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .START_UP_DELAY (SUD),
        .HSYNC_DELAY    (HSD),
        .ADDR_W         (AW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .busy      (busy),
        .ctrl_done (ctrl_done),
        .bus       (bus)
    );

    always #5 HCLK = ~HCLK;

    // byte k of word a = {a, k+1}: every lane and every word distinct
    function automatic logic [47:0] pat(input logic [AW-1:0] a);
        logic [47:0] w;
        for (int k = 0; k < 6; k++) w[k*8 +: 8] = {a, 4'(k + 1)};
        return w;
    endfunction

    // synchronous RAM: data valid the cycle after the read strobe
    always_ff @(posedge HCLK)
        if (bus.mem_rd) bus.mem_rdata <= pat(bus.mem_addr);

    typedef struct {
        int first;  // cycle of the first read of the row (start cycle = 0)
        int base;   // word address of its first pair
    } row_t;

    row_t        rows [4];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] exp_hold;

    function automatic logic [47:0] pix_bus();
        return {bus.DATA_R1, bus.DATA_G1, bus.DATA_B1,
                bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};
    endfunction

    task automatic chk(input string name, input int c, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " VSYNC"},  0, 48'(bus.VSYNC),    48'd0);
        chk({tag, " HSYNC"},  0, 48'(bus.HSYNC),    48'd0);
        chk({tag, " mem_rd"}, 0, 48'(bus.mem_rd),   48'd0);
        chk({tag, " addr"},   0, 48'(bus.mem_addr), 48'd0);
        chk({tag, " busy"},   0, 48'(busy),         48'd0);
        chk({tag, " done"},   0, 48'(ctrl_done),    48'd0);
        chk({tag, " DATA"},   0, pix_bus(),         48'd0);
    endtask

    // One full frame, entered just after a rising edge; cycle 0 raises start.
    // inj: extra start cycle while busy; at_done: also raise start in the done cycle.
    task automatic run_frame(input int inj, input bit at_done);
        logic          prev_rd   = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic          exp_rd;
        logic [AW-1:0] exp_addr;
        int            hs_cnt    = 0;
        int            done_cnt  = 0;
        for (int c = 0; c <= LAST; c++) begin
            start = (c == 0) || (c == inj) || (at_done && c == LAST);
            @(negedge HCLK);
            exp_rd   = 1'b0;
            exp_addr = '0;
            for (int r = 0; r < 4; r++)
                if (c >= rows[r].first && c < rows[r].first + W/2) begin
                    exp_rd   = 1'b1;
                    exp_addr = AW'(rows[r].base + c - rows[r].first);
                end
            if (prev_rd) exp_hold = pat(prev_addr);
            chk("VSYNC",     c, 48'(bus.VSYNC),    48'(c >= 1 && c <= SUD));
            chk("mem_rd",    c, 48'(bus.mem_rd),   48'(exp_rd));
            chk("mem_addr",  c, 48'(bus.mem_addr), 48'(exp_addr));
            chk("HSYNC",     c, 48'(bus.HSYNC),    48'(prev_rd));
            chk("DATA",      c, pix_bus(),         exp_hold);
            chk("busy",      c, 48'(busy),         48'(c >= 1 && c < LAST));
            chk("ctrl_done", c, 48'(ctrl_done),    48'(c == LAST));
            hs_cnt   += int'(bus.HSYNC);
            done_cnt += int'(ctrl_done);
            prev_rd   = exp_rd;
            prev_addr = exp_addr;
            @(posedge HCLK);
            #1;
        end
        start = 1'b0;
        chk("hsync_count", LAST, 48'(hs_cnt),   48'd16);
        chk("done_count",  LAST, 48'(done_cnt), 48'd1);
    endtask

    initial begin
        int bad;
        rows[0] = '{first: 6,  base: 12};
        rows[1] = '{first: 12, base: 8};
        rows[2] = '{first: 18, base: 4};
        rows[3] = '{first: 24, base: 0};
        exp_hold = '0;

        // reset: everything low
        #2 HRESETn = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // no start: stays idle for 100 cycles
        bad = 0;
        repeat (100) begin
            @(negedge HCLK);
            if (busy || bus.VSYNC || bus.HSYNC || bus.mem_rd || ctrl_done) bad++;
        end
        chk("idle_100", 0, 48'(bad), 48'd0);
        @(posedge HCLK);
        #1;

        // frame 1, start also raised in its ctrl_done cycle (dropped),
        // then back-to-back frame 2 starting the very next cycle
        run_frame(-1, 1'b1);
        run_frame(-1, 1'b0);

        // frame 3 with a start pulse during row 2 data
        run_frame(19, 1'b0);

        // reset asserted mid-way through row 1 data
        start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        for (int c = 1; c < 13; c++) begin
            @(posedge HCLK);
            #1;
        end
        @(negedge HCLK);
        chk("pre_rst HSYNC", 13, 48'(bus.HSYNC),    48'd1);
        chk("pre_rst addr",  13, 48'(bus.mem_addr), 48'd9);
        HRESETn = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        repeat (2) begin
            @(posedge HCLK);
            #1;
        end
        chk("post_rst busy", 0, 48'(busy), 48'd0);
        exp_hold = '0;
        run_frame(-1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
